// File: rtl/gbc_rtc_pkg.sv
// Shared definitions for the MBC3 real-time clock: register indexes, field widths,
// DH bit positions and rollover helpers.
package gbc_rtc_pkg;

  typedef enum logic [2:0] {
    RTC_S     = 3'd0,
    RTC_M     = 3'd1,
    RTC_H     = 3'd2,
    RTC_DL    = 3'd3,
    RTC_DH    = 3'd4,
    RTC_LATCH = 3'd5
  } rtcIdx_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 9;

  localparam int DH_DAY8  = 0;
  localparam int DH_HALT  = 6;
  localparam int DH_CARRY = 7;

  localparam logic [SEC_W-1:0]  SM_LIMIT  = 6'd59;
  localparam logic [HOUR_W-1:0] H_LIMIT   = 5'd23;
  localparam logic [DAY_W-1:0]  DAY_LIMIT = 9'd511;

  // Out-of-range values simply count on and wrap through zero without a carry.
  function automatic logic [SEC_W:0] incSixty(input logic [SEC_W-1:0] v);
    if (v == SM_LIMIT) incSixty = {1'b1, {SEC_W{1'b0}}};
    else               incSixty = {1'b0, v + SEC_W'(1)};
  endfunction

  function automatic logic [HOUR_W:0] incHour(input logic [HOUR_W-1:0] v);
    if (v == H_LIMIT) incHour = {1'b1, {HOUR_W{1'b0}}};
    else              incHour = {1'b0, v + HOUR_W'(1)};
  endfunction

endpackage

// File: rtl/gbc_rtc_prescaler.sv
// Divides the system clock down to a one-cycle tick every DIVIDE enabled cycles.
// Clear has priority and restarts the count from zero.
module gbc_rtc_prescaler #(
  parameter int DIVIDE = 4194304
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIVIDE - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == TC);

  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= tick ? '0 : count + CNT_W'(1);
  end

endmodule

// File: rtl/gbc_mbc3_rtc.sv
// MBC3 RTC Wishbone target: live S/M/H/day counters at 1 Hz, latched snapshot for
// reads, halt and sticky day-carry flags.
module gbc_mbc3_rtc
  import gbc_rtc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 4194304
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tickEnable,
  input  logic       busCyc,
  input  logic       busStb,
  input  logic       busWe,
  input  logic [2:0] busAddr,
  input  logic [7:0] busDatToTarget,
  output logic [7:0] busDatToInitiator,
  output logic       busAck,
  output logic       busStall
);

  logic [SEC_W-1:0]  sec,  secL;
  logic [MIN_W-1:0]  mins, minsL;
  logic [HOUR_W-1:0] hrs,  hrsL;
  logic [DAY_W-1:0]  day,  dayL;
  logic              halt, haltL, carry, carryL;
  logic              latchArm;

  logic              accept, wrEn, tick;
  rtcIdx_t           idx;
  logic [7:0]        readMux;

  logic              sCarry, mCarry, hCarry, dayStep;
  logic [SEC_W-1:0]  secInc,  secNext;
  logic [MIN_W-1:0]  minsInc, minsNext;
  logic [HOUR_W-1:0] hrsInc,  hrsNext;
  logic [DAY_W-1:0]  dayNext;
  logic              carryNext;

  assign accept   = busCyc && busStb;
  assign wrEn     = accept && busWe;
  assign idx      = rtcIdx_t'(busAddr);
  assign busStall = 1'b0;

  gbc_rtc_prescaler #(.DIVIDE(CLK_FREQ_HZ)) uPrescaler (
    .clk   (clk),
    .rst   (rst),
    .enable(tickEnable && !halt),
    .clear (wrEn && (idx == RTC_S)),
    .tick  (tick)
  );

  // Ripple is computed from pre-write values so a same-cycle write only overrides its own field.
  always_comb begin
    {sCarry, secInc}  = incSixty(sec);
    {mCarry, minsInc} = incSixty(mins);
    {hCarry, hrsInc}  = incHour(hrs);
    dayStep   = tick && sCarry && mCarry && hCarry;
    secNext   = tick ? secInc : sec;
    minsNext  = (tick && sCarry) ? minsInc : mins;
    hrsNext   = (tick && sCarry && mCarry) ? hrsInc : hrs;
    dayNext   = dayStep ? day + DAY_W'(1) : day;
    carryNext = carry | (dayStep && (day == DAY_LIMIT));
  end

  always_comb begin
    readMux = 8'hFF;
    case (idx)
      RTC_S:   readMux = {2'b11, secL};
      RTC_M:   readMux = {2'b11, minsL};
      RTC_H:   readMux = {3'b111, hrsL};
      RTC_DL:  readMux = dayL[7:0];
      RTC_DH:  readMux = {carryL, haltL, 5'b11111, dayL[8]};
      default: readMux = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec  <= '0; mins  <= '0; hrs  <= '0; day  <= '0; halt  <= 1'b0; carry  <= 1'b0;
      secL <= '0; minsL <= '0; hrsL <= '0; dayL <= '0; haltL <= 1'b0; carryL <= 1'b0;
      latchArm          <= 1'b0;
      busAck            <= 1'b0;
      busDatToInitiator <= 8'hFF;
    end else begin
      busAck <= accept;
      if (accept) busDatToInitiator <= readMux;

      sec   <= secNext;
      mins  <= minsNext;
      hrs   <= hrsNext;
      day   <= dayNext;
      carry <= carryNext;

      if (wrEn) begin
        case (idx)
          RTC_S: begin
            sec  <= busDatToTarget[SEC_W-1:0];
            secL <= busDatToTarget[SEC_W-1:0];
          end
          RTC_M: begin
            mins  <= busDatToTarget[MIN_W-1:0];
            minsL <= busDatToTarget[MIN_W-1:0];
          end
          RTC_H: begin
            hrs  <= busDatToTarget[HOUR_W-1:0];
            hrsL <= busDatToTarget[HOUR_W-1:0];
          end
          RTC_DL: begin
            day[7:0]  <= busDatToTarget;
            dayL[7:0] <= busDatToTarget;
          end
          RTC_DH: begin
            day[8]  <= busDatToTarget[DH_DAY8];
            halt    <= busDatToTarget[DH_HALT];
            carry   <= busDatToTarget[DH_CARRY];
            dayL[8] <= busDatToTarget[DH_DAY8];
            haltL   <= busDatToTarget[DH_HALT];
            carryL  <= busDatToTarget[DH_CARRY];
          end
          RTC_LATCH: begin
            if (!busDatToTarget[0]) begin
              latchArm <= 1'b1;
            end else if (latchArm) begin
              secL     <= sec;
              minsL    <= mins;
              hrsL     <= hrs;
              dayL     <= day;
              haltL    <= halt;
              carryL   <= carry;
              latchArm <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
